// File: rtl/nand_flash_pkg.sv
// Shared definitions for the dual-core NAND flash arbiter.
// Contents: sequencing state encoding, bus widths and the status byte
// reported when the optional watchdog (NF_ARB_TIMEOUT_EN) fires.
package nand_flash_pkg;

  localparam int unsigned CMD_W  = 8;
  localparam int unsigned RAM_AW = 10;
  localparam int unsigned DATA_W = 32;

  localparam logic [CMD_W-1:0] TIMEOUT_STATUS = 8'hFF;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWaitBusy,
    StWaitDone,
    StFinish
  } state_e;

endpackage

// File: rtl/nand_flash_arbiter_if.sv
// Bundle of every core-side and flash-side signal handled by the arbiter.
//   slave  : arbiter view (requests, RAM ports, done/status in; grants,
//            completions, muxed RAM port, controller command out).
//   master : environment view (cores plus flash top level).
interface nand_flash_arbiter_if;
  import nand_flash_pkg::*;

  // Core side
  logic [1:0]        req;
  logic [CMD_W-1:0]  cmd0;
  logic [CMD_W-1:0]  cmd1;
  logic [DATA_W-1:0] c0_addr0;
  logic [DATA_W-1:0] c0_addr1;
  logic [DATA_W-1:0] c1_addr0;
  logic [DATA_W-1:0] c1_addr1;
  logic [1:0]        ack;
  logic [1:0]        cmp;
  logic [1:0]        err;
  logic              owner;
  logic              busy;
  logic              c0_ram_we;
  logic              c1_ram_we;
  logic [RAM_AW-1:0] c0_ram_addr;
  logic [RAM_AW-1:0] c1_ram_addr;
  logic [DATA_W-1:0] c0_ram_wdata;
  logic [DATA_W-1:0] c1_ram_wdata;

  // Flash side
  logic              ram_we;
  logic [RAM_AW-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [CMD_W-1:0]  nfcr;
  logic [DATA_W-1:0] nf_addr0;
  logic [DATA_W-1:0] nf_addr1;
  logic              done;
  logic [CMD_W-1:0]  status;
  logic [CMD_W-1:0]  op_status;

  modport slave (
    input  req, cmd0, cmd1, c0_addr0, c0_addr1, c1_addr0, c1_addr1,
    input  c0_ram_we, c1_ram_we, c0_ram_addr, c1_ram_addr, c0_ram_wdata, c1_ram_wdata,
    input  done, status,
    output ack, cmp, err, owner, busy, ram_we, ram_addr, ram_wdata,
    output nfcr, nf_addr0, nf_addr1, op_status
  );

  modport master (
    output req, cmd0, cmd1, c0_addr0, c0_addr1, c1_addr0, c1_addr1,
    output c0_ram_we, c1_ram_we, c0_ram_addr, c1_ram_addr, c0_ram_wdata, c1_ram_wdata,
    output done, status,
    input  ack, cmp, err, owner, busy, ram_we, ram_addr, ram_wdata,
    input  nfcr, nf_addr0, nf_addr1, op_status
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant.
//   clk, rst : clock, synchronous active-high reset (core0 favoured first)
//   req      : request bits
//   advance  : commit the current winner; the other core gets priority next
//   winner   : index of the core that would be granted now
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic       winner
);

  logic prio_q;

  // Single requester wins outright; the pointer only breaks ties.
  always_comb winner = (req == 2'b11) ? prio_q : req[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q <= 1'b0;
    end else if (advance) begin
      prio_q <= ~winner;
    end
  end

endmodule

// File: rtl/nand_flash_arbiter.sv
// Shares one NAND flash controller and its buffer RAM port between two cores.
// Grants round-robin, issues the command for one cycle, waits for the
// controller busy/idle cycle and returns cmp/err/op_status to the owner.
//   clk, rst : clock, synchronous active-high reset
//   bus      : nand_flash_arbiter_if.slave (core requests, RAM ports, controller)
// Optional macro NF_ARB_TIMEOUT_EN adds an 18-bit watchdog on the controller
// busy phase; on expiry the operation finishes with err and op_status 8'hFF.
module nand_flash_arbiter
  import nand_flash_pkg::*;
#(
  parameter int unsigned BUSY_WAIT = 8
`ifdef NF_ARB_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT   = 262143
`endif
) (
  input logic                 clk,
  input logic                 rst,
  nand_flash_arbiter_if.slave bus
);

  localparam int unsigned BcntW = (BUSY_WAIT > 1) ? $clog2(BUSY_WAIT) : 1;

  state_e            state_q, state_d;
  logic [1:0]        ack_q, ack_d, cmp_q, cmp_d, err_q, err_d;
  logic              owner_q, owner_d, busy_q, busy_d;
  logic [CMD_W-1:0]  cmd_q, cmd_d, nfcr_q, nfcr_d, op_status_q, op_status_d;
  logic [DATA_W-1:0] addr0_q, addr0_d, addr1_q, addr1_d;
  logic [BcntW-1:0]  bcnt_q, bcnt_d;
`ifdef NF_ARB_TIMEOUT_EN
  logic [17:0]       to_cnt_q, to_cnt_d;
`endif

  logic             win, advance;
  logic [CMD_W-1:0] win_cmd;

  rr_arb2 u_rr_arb2 (
    .clk     (clk),
    .rst     (rst),
    .req     (bus.req),
    .advance (advance),
    .winner  (win)
  );

  assign win_cmd = win ? bus.cmd1 : bus.cmd0;

  always_comb begin
    state_d     = state_q;
    ack_d       = 2'b00;
    cmp_d       = 2'b00;
    err_d       = 2'b00;
    owner_d     = owner_q;
    busy_d      = busy_q;
    cmd_d       = cmd_q;
    nfcr_d      = '0;
    addr0_d     = addr0_q;
    addr1_d     = addr1_q;
    op_status_d = op_status_q;
    bcnt_d      = bcnt_q;
    advance     = 1'b0;
`ifdef NF_ARB_TIMEOUT_EN
    to_cnt_d    = to_cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if ((bus.req != 2'b00) && bus.done) begin
          ack_d[win] = 1'b1;
          if (win_cmd == '0) begin
            // Invalid command: reject on the spot, pointer untouched.
            cmp_d[win] = 1'b1;
            err_d[win] = 1'b1;
          end else begin
            advance = 1'b1;
            owner_d = win;
            busy_d  = 1'b1;
            cmd_d   = win_cmd;
            addr0_d = win ? bus.c1_addr0 : bus.c0_addr0;
            addr1_d = win ? bus.c1_addr1 : bus.c0_addr1;
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        nfcr_d  = cmd_q;
        bcnt_d  = '0;
        state_d = StWaitBusy;
      end
      StWaitBusy: begin
        if (!bus.done) begin
`ifdef NF_ARB_TIMEOUT_EN
          to_cnt_d = '0;
`endif
          state_d = StWaitDone;
        end else if (bcnt_q == BcntW'(BUSY_WAIT - 1)) begin
          // Controller never went busy: report a start failure.
          cmp_d[owner_q] = 1'b1;
          err_d[owner_q] = 1'b1;
          busy_d         = 1'b0;
          state_d        = StFinish;
        end else begin
          bcnt_d = bcnt_q + BcntW'(1);
        end
      end
      StWaitDone: begin
        if (bus.done) begin
          op_status_d    = bus.status;
          cmp_d[owner_q] = 1'b1;
          busy_d         = 1'b0;
          state_d        = StFinish;
        end
`ifdef NF_ARB_TIMEOUT_EN
        else if (to_cnt_q == 18'(TIMEOUT)) begin
          op_status_d    = TIMEOUT_STATUS;
          cmp_d[owner_q] = 1'b1;
          err_d[owner_q] = 1'b1;
          busy_d         = 1'b0;
          state_d        = StFinish;
        end else begin
          to_cnt_d = to_cnt_q + 18'd1;
        end
`endif
      end
      // Completion is already signalled; this cycle only guarantees a gap.
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      ack_q       <= 2'b00;
      cmp_q       <= 2'b00;
      err_q       <= 2'b00;
      owner_q     <= 1'b0;
      busy_q      <= 1'b0;
      cmd_q       <= '0;
      nfcr_q      <= '0;
      addr0_q     <= '0;
      addr1_q     <= '0;
      op_status_q <= '0;
      bcnt_q      <= '0;
`ifdef NF_ARB_TIMEOUT_EN
      to_cnt_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ack_q       <= ack_d;
      cmp_q       <= cmp_d;
      err_q       <= err_d;
      owner_q     <= owner_d;
      busy_q      <= busy_d;
      cmd_q       <= cmd_d;
      nfcr_q      <= nfcr_d;
      addr0_q     <= addr0_d;
      addr1_q     <= addr1_d;
      op_status_q <= op_status_d;
      bcnt_q      <= bcnt_d;
`ifdef NF_ARB_TIMEOUT_EN
      to_cnt_q    <= to_cnt_d;
`endif
    end
  end

  // Buffer RAM mux: owner only while busy, core0 first while idle.
  logic ram_sel;
  always_comb begin
    if (busy_q) begin
      ram_sel    = owner_q;
      bus.ram_we = owner_q ? bus.c1_ram_we : bus.c0_ram_we;
    end else begin
      ram_sel    = ~bus.c0_ram_we;
      bus.ram_we = bus.c0_ram_we | bus.c1_ram_we;
    end
    bus.ram_addr  = ram_sel ? bus.c1_ram_addr : bus.c0_ram_addr;
    bus.ram_wdata = ram_sel ? bus.c1_ram_wdata : bus.c0_ram_wdata;
  end

  assign bus.ack       = ack_q;
  assign bus.cmp       = cmp_q;
  assign bus.err       = err_q;
  assign bus.owner     = owner_q;
  assign bus.busy      = busy_q;
  assign bus.nfcr      = nfcr_q;
  assign bus.nf_addr0  = addr0_q;
  assign bus.nf_addr1  = addr1_q;
  assign bus.op_status = op_status_q;

endmodule

// File: tb/tb_nand_flash_arbiter.sv
// Self-checking bench for nand_flash_arbiter. A small controller model
// answers each nfcr pulse; expected completions are queued at stimulus time
// and checked by a monitor whenever cmp pulses.
module tb_nand_flash_arbiter;

  typedef struct {
    logic       core;
    logic       err;
    logic [7:0] status;
  } exp_t;

  logic clk;
  logic rst;
  nand_flash_arbiter_if bus ();

  nand_flash_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   tests_run = 0;
  int   tests_failed = 0;
  exp_t sb[$];

  bit         stuck = 1'b0;
  int         busy_len = 5;
  logic [7:0] model_status = 8'h40;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Controller model: done falls after seeing nfcr, rises busy_len cycles later.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bus.nfcr != 8'h00 && !stuck) begin
        bus.done = 1'b0;
        repeat (busy_len) @(posedge clk);
        #1;
        bus.status = model_status;
        bus.done   = 1'b1;
      end
    end
  end

  // Scoreboard monitor.
  initial begin
    exp_t       e;
    logic [1:0] exp_cmp, exp_err;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && bus.cmp != 2'b00) begin
        tests_run++;
        if (sb.size() == 0) begin
          tests_failed++;
          $display("FAIL cmp_unexpected: cmp=%b err=%b, required no completion", bus.cmp, bus.err);
        end else begin
          e       = sb.pop_front();
          exp_cmp = 2'b01 << e.core;
          exp_err = e.err ? exp_cmp : 2'b00;
          if (bus.cmp !== exp_cmp || bus.err !== exp_err ||
              (!e.err && bus.op_status !== e.status)) begin
            tests_failed++;
            $display("FAIL completion: cmp=%b err=%b op_status=%h, required cmp=%b err=%b status=%h",
                     bus.cmp, bus.err, bus.op_status, exp_cmp, exp_err, e.status);
          end
        end
      end
      if (!rst && (bus.err & ~bus.cmp) != 2'b00) begin
        tests_run++;
        tests_failed++;
        $display("FAIL err_without_cmp: err=%b cmp=%b", bus.err, bus.cmp);
      end
    end
  end

  task automatic clear_inputs();
    bus.req          = 2'b00;
    bus.cmd0         = 8'h00;
    bus.cmd1         = 8'h00;
    bus.c0_addr0     = '0;
    bus.c0_addr1     = '0;
    bus.c1_addr0     = '0;
    bus.c1_addr1     = '0;
    bus.c0_ram_we    = 1'b0;
    bus.c1_ram_we    = 1'b0;
    bus.c0_ram_addr  = '0;
    bus.c1_ram_addr  = '0;
    bus.c0_ram_wdata = '0;
    bus.c1_ram_wdata = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic do_req(input logic core, input logic [7:0] cmd, input logic [31:0] a0,
                        input logic [31:0] a1, output int lat);
    if (core) begin
      bus.cmd1 = cmd; bus.c1_addr0 = a0; bus.c1_addr1 = a1;
    end else begin
      bus.cmd0 = cmd; bus.c0_addr0 = a0; bus.c0_addr1 = a1;
    end
    bus.req[core] = 1'b1;
    lat = 0;
    while (lat < 20) begin
      tick();
      lat++;
      if (bus.ack[core]) break;
    end
    bus.req[core] = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!bus.busy) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if ({bus.ack, bus.cmp, bus.err, bus.owner, bus.busy} !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_ctrl: ack=%b cmp=%b err=%b owner=%b busy=%b, required all 0",
               bus.ack, bus.cmp, bus.err, bus.owner, bus.busy);
    end
    tests_run++;
    if ({bus.nfcr, bus.nf_addr0, bus.nf_addr1, bus.op_status} !== 80'h0) begin
      tests_failed++;
      $display("FAIL reset_data: nfcr=%h a0=%h a1=%h op_status=%h, required 0",
               bus.nfcr, bus.nf_addr0, bus.nf_addr1, bus.op_status);
    end
  endtask

  task automatic test_single();
    int lat;
    bit ok;
    busy_len = 5; model_status = 8'hC0;
    sb.push_back('{core: 1'b0, err: 1'b0, status: 8'hC0});
    do_req(1'b0, 8'h01, 32'h100, 32'h0, lat);
    tests_run++;
    if (lat !== 1) begin
      tests_failed++; $display("FAIL single_ack_latency: %0d cycles, required 1", lat);
    end
    tick();
    tests_run++;
    if (bus.nfcr !== 8'h01 || bus.nf_addr0 !== 32'h100 || bus.nf_addr1 !== 32'h0) begin
      tests_failed++;
      $display("FAIL single_issue: nfcr=%h a0=%h a1=%h, required 01/00000100/00000000",
               bus.nfcr, bus.nf_addr0, bus.nf_addr1);
    end
    tick();
    tests_run++;
    if (bus.nfcr !== 8'h00) begin
      tests_failed++; $display("FAIL single_nfcr_width: nfcr=%h, required 00", bus.nfcr);
    end
    wait_idle(ok);
    tests_run++;
    if (!ok || bus.op_status !== 8'hC0 || bus.owner !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_done: ok=%b op_status=%h owner=%b, required 1/C0/0",
               ok, bus.op_status, bus.owner);
    end
  endtask

  task automatic test_simultaneous();
    int         lat;
    bit         ok;
    logic       exp;
    logic [1:0] exp_ack;
    do_reset();
    model_status = 8'h40;
    for (int i = 0; i < 3; i++) begin
      exp     = logic'(i % 2);
      exp_ack = 2'b01 << exp;
      sb.push_back('{core: exp, err: 1'b0, status: 8'h40});
      bus.cmd0 = 8'h02; bus.cmd1 = 8'h03;
      bus.req  = 2'b11;
      lat = 0;
      while (lat < 20) begin
        tick();
        lat++;
        if (bus.ack != 2'b00) break;
      end
      bus.req = 2'b00;
      tests_run++;
      if (bus.ack !== exp_ack || lat !== 1 || bus.owner !== exp) begin
        tests_failed++;
        $display("FAIL rr_grant%0d: ack=%b lat=%0d owner=%b, required ack=%b lat=1 owner=%b",
                 i, bus.ack, lat, bus.owner, exp_ack, exp);
      end
      wait_idle(ok);
      tests_run++;
      if (!ok) begin
        tests_failed++; $display("FAIL rr_idle%0d: busy stuck 1, required 0", i);
      end
    end
  endtask

  task automatic test_zero_cmd();
    bit ok;
    bit quiet;
    do_reset();
    sb.push_back('{core: 1'b1, err: 1'b1, status: 8'h00});
    bus.cmd1 = 8'h00; bus.req = 2'b10;
    tick();
    bus.req = 2'b00;
    tests_run++;
    if (bus.ack !== 2'b10 || bus.cmp !== 2'b10 || bus.err !== 2'b10) begin
      tests_failed++;
      $display("FAIL zero_reject: ack=%b cmp=%b err=%b, required 10/10/10",
               bus.ack, bus.cmp, bus.err);
    end
    quiet = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (bus.nfcr !== 8'h00 || bus.busy !== 1'b0) quiet = 1'b0;
      tick();
    end
    tests_run++;
    if (!quiet) begin
      tests_failed++; $display("FAIL zero_quiet: controller activity seen, required none");
    end
    // Pointer must still favour core0.
    sb.push_back('{core: 1'b0, err: 1'b0, status: model_status});
    bus.cmd0 = 8'h02; bus.cmd1 = 8'h03; bus.req = 2'b11;
    tick();
    bus.req = 2'b00;
    tests_run++;
    if (bus.ack !== 2'b01) begin
      tests_failed++; $display("FAIL zero_next0: ack=%b, required 01", bus.ack);
    end
    wait_idle(ok);
    // Pointer now favours core1; a rejected core1 request must not move it.
    sb.push_back('{core: 1'b1, err: 1'b1, status: 8'h00});
    bus.cmd1 = 8'h00; bus.req = 2'b10;
    tick();
    bus.req = 2'b00;
    tick();
    sb.push_back('{core: 1'b1, err: 1'b0, status: model_status});
    bus.cmd1 = 8'h07; bus.req = 2'b11;
    tick();
    bus.req = 2'b00;
    tests_run++;
    if (bus.ack !== 2'b10) begin
      tests_failed++; $display("FAIL zero_next1: ack=%b, required 10", bus.ack);
    end
    wait_idle(ok);
  endtask

  task automatic test_stuck();
    int lat;
    int n;
    stuck = 1'b1;
    sb.push_back('{core: 1'b0, err: 1'b1, status: 8'h00});
    do_req(1'b0, 8'h04, 32'h200, 32'h1, lat);
    tick();
    n = 0;
    while (bus.busy && n < 40) begin
      tick();
      n++;
    end
    tests_run++;
    if (n !== 8) begin
      tests_failed++; $display("FAIL stuck_timeout: err after %0d cycles, required 8", n);
    end
    stuck = 1'b0;
    tick();
  endtask

  task automatic test_ram();
    int lat;
    bit ok;
    busy_len = 20; model_status = 8'h11;
    sb.push_back('{core: 1'b0, err: 1'b0, status: 8'h11});
    do_req(1'b0, 8'h05, 32'h300, 32'h2, lat);
    tick();
    bus.c1_ram_we = 1'b1; bus.c1_ram_addr = 10'h3FF; bus.c1_ram_wdata = 32'hDEAD_BEEF;
    #1;
    tests_run++;
    if (bus.ram_we !== 1'b0) begin
      tests_failed++; $display("FAIL ram_block_c1: ram_we=%b, required 0", bus.ram_we);
    end
    bus.c0_ram_we = 1'b1; bus.c0_ram_addr = 10'h012; bus.c0_ram_wdata = 32'hA5A5_0001;
    #1;
    tests_run++;
    if ({bus.ram_we, bus.ram_addr, bus.ram_wdata} !== {1'b1, 10'h012, 32'hA5A5_0001}) begin
      tests_failed++;
      $display("FAIL ram_pass_c0: we=%b addr=%h data=%h, required 1/012/a5a50001",
               bus.ram_we, bus.ram_addr, bus.ram_wdata);
    end
    bus.c0_ram_we = 1'b0; bus.c1_ram_we = 1'b0;
    wait_idle(ok);
    bus.c0_ram_we = 1'b1; bus.c0_ram_addr = 10'h001; bus.c0_ram_wdata = 32'h1;
    bus.c1_ram_we = 1'b1; bus.c1_ram_wdata = 32'h2;
    #1;
    tests_run++;
    if ({bus.ram_we, bus.ram_addr, bus.ram_wdata} !== {1'b1, 10'h001, 32'h1}) begin
      tests_failed++;
      $display("FAIL ram_idle_prio: we=%b addr=%h data=%h, required 1/001/00000001",
               bus.ram_we, bus.ram_addr, bus.ram_wdata);
    end
    bus.c0_ram_we = 1'b0;
    #1;
    tests_run++;
    if ({bus.ram_we, bus.ram_addr, bus.ram_wdata} !== {1'b1, 10'h3FF, 32'h2}) begin
      tests_failed++;
      $display("FAIL ram_idle_c1: we=%b addr=%h data=%h, required 1/3ff/00000002",
               bus.ram_we, bus.ram_addr, bus.ram_wdata);
    end
    bus.c1_ram_we = 1'b0;
    tick();
  endtask

  task automatic test_reset_wait_done();
    int lat;
    bit ok;
    int n;
    busy_len = 20; model_status = 8'h22;
    do_req(1'b0, 8'h06, 32'h400, 32'h3, lat);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests_run++;
    if (bus.nfcr !== 8'h00 || bus.busy !== 1'b0 || bus.cmp !== 2'b00) begin
      tests_failed++;
      $display("FAIL mid_reset: nfcr=%h busy=%b cmp=%b, required 00/0/00",
               bus.nfcr, bus.busy, bus.cmp);
    end
    n = 0;
    while (!bus.done && n < 50) begin
      tick();
      n++;
    end
    repeat (2) tick();
    sb.push_back('{core: 1'b1, err: 1'b0, status: 8'h22});
    do_req(1'b1, 8'h05, 32'h500, 32'h4, lat);
    tests_run++;
    if (lat !== 1 || bus.owner !== 1'b1) begin
      tests_failed++;
      $display("FAIL post_reset_grant: lat=%0d owner=%b, required 1/1", lat, bus.owner);
    end
    wait_idle(ok);
    tests_run++;
    if (!ok || bus.op_status !== 8'h22) begin
      tests_failed++;
      $display("FAIL post_reset_done: ok=%b op_status=%h, required 1/22", ok, bus.op_status);
    end
  endtask

  initial begin
    rst        = 1'b1;
    bus.done   = 1'b1;
    bus.status = 8'h00;
    clear_inputs();
    test_reset();
    test_single();
    test_simultaneous();
    test_zero_cmd();
    test_stuck();
    test_ram();
    test_reset_wait_done();
    repeat (3) tick();
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: %0d completions outstanding, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/nand_flash_arbiter.md
Name: nand_flash_arbiter

Overview:
- Shares the single NAND flash controller and its buffer RAM port between the two cores of the dual-core system.
- Each core posts a command (nfcr byte plus two 32-bit address words) with a req/ack handshake.
- The arbiter grants round-robin, sequences the controller (issue, busy, done) and returns completion and status to the owning core only.
- It sits between the two core bus interfaces and the flash top level.

Parameters:
- BUSY_WAIT, 8: max cycles to wait for controller done to fall after issue before declaring a start failure.
- TIMEOUT, 262143: watchdog cycle limit for one operation (18-bit, matches cycle counter width); used only with the optional feature.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- req  in  2  per-core request level; held until ack.
- cmd0, cmd1  in  8 each  nfcr command byte per core; nonzero = valid.
- c0_addr0, c0_addr1, c1_addr0, c1_addr1  in  32 each  flash address words per core.
- ack  out  2  one-cycle pulse: request accepted.
- cmp  out  2  one-cycle pulse: operation finished for that core.
- err  out  2  one-cycle pulse, coincident with cmp: failed operation.
- owner  out  1  index of the current or last granted core.
- busy  out  1  high from grant until release.
- c0_ram_we, c1_ram_we  in  1 each  per-core buffer RAM write enable.
- c0_ram_addr, c1_ram_addr  in  10 each  per-core buffer RAM word address.
- c0_ram_wdata, c1_ram_wdata  in  32 each  per-core buffer RAM write data.
- ram_we  out  1  muxed write enable to the buffer RAM.
- ram_addr  out  10  muxed buffer RAM word address.
- ram_wdata  out  32  muxed buffer RAM write data.
- nfcr  out  8  command byte to the controller.
- nf_addr0, nf_addr1  out  32 each  address words to the controller.
- done  in  1  controller level: high = idle.
- status  in  8  controller status byte.
- op_status  out  8  status latched at completion.

Behaviour:
- Reset values: ack, cmp, err = 0; nfcr = 0; nf_addr0/1 = 0; owner = 0; busy = 0; op_status = 0; state = IDLE; round-robin pointer = core0 first.
- IDLE: if req has any bit set and done = 1, grant. With both requesting, the core not equal to owner wins; after reset core0 wins. The winner's address words are latched into nf_addr0/1 and its command is latched internally; ack[winner] pulses; busy = 1; go to ISSUE.
- Requests with cmd = 0 are rejected: ack and cmp pulse in the same cycle, err = 1, no controller activity, and the pointer does not advance.
- ISSUE: drive nfcr = command for exactly one cycle, then nfcr = 0. Go to WAIT_BUSY.
- WAIT_BUSY: wait for done = 0. If BUSY_WAIT cycles elapse without it, go to FINISH with err.
- WAIT_DONE: wait for done = 1. Then latch op_status = status and go to FINISH.
- FINISH: cmp[owner] pulses one cycle (err if flagged); busy = 0; go to IDLE. No new grant is made in this cycle, so there is at least one idle cycle between operations.
- Grant latency: req high to ack = 1 cycle; ack to nfcr pulse = 1 cycle.
- RAM mux: when busy, only the owner's ram_we passes and the other core's write is dropped. When idle, core0 has priority; if both cores assert we in the same cycle, core1's write is dropped.
- req deasserted after ack has no effect: an operation, once accepted, runs to completion.
- Reset mid-operation returns to IDLE immediately with nfcr = 0. No cmp is issued.
- A core re-requesting in the same cycle as its cmp is accepted the next cycle if the other core is not requesting.

Optional Feature:
- Macro: NF_ARB_TIMEOUT_EN.
- Defined: an 18-bit counter runs in WAIT_DONE. When it reaches TIMEOUT, the arbiter goes to FINISH with err = 1 and op_status = 8'hFF.
- Undefined: WAIT_DONE waits indefinitely; no counter is synthesized.

Decomposition:
- Package nand_flash_pkg holds the state encoding (IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, FINISH), the widths (CMD_W = 8, RAM_AW = 10, DATA_W = 32) and the timeout status constant 8'hFF.
- Sub-module rr_arb2: a 2-way round-robin grant with pointer update on grant. Pure sequencing and muxing remain in the top.

Test Plan:
- Single request: req = 2'b01, cmd0 = 8'h01, addrs 32'h100 / 32'h0. Require ack[0] at +1, nfcr = 8'h01 for one cycle, then with done low 5 cycles and status = 8'hC0, cmp[0] pulses, op_status = 8'hC0, err = 0.
- Simultaneous requests: req = 2'b11 repeatedly from reset. Grants alternate core0, core1, core0, and each cmp goes only to its owner.
- Zero command: cmd1 = 8'h00, req = 2'b10. Require ack[1], cmp[1] and err[1] in the same cycle, nfcr stays 0, and the next grant still goes to core0.
- Stuck controller: done held high after issue. Require err after BUSY_WAIT = 8 cycles; with NF_ARB_TIMEOUT_EN, done held low for 262143 cycles gives err with op_status = 8'hFF.
- RAM arbitration: during a core0 operation, c1_ram_we = 1 with address 10'h3FF. Require ram_we = 0 and no write to the buffer RAM; core0 writes pass through unchanged.
- Reset in WAIT_DONE: require the next cycle shows nfcr = 0, busy = 0, no cmp, and a fresh request is granted normally.
